// File: rtl/pwm_pkg.sv
// Shared constants and the configuration bundle type for the PWM output stage.
// The optional duty shadow register is enabled by defining PWM_SHADOW_EN.
package pwm_pkg;

    localparam int unsigned PWM_BITS         = 8;
    localparam int unsigned NUM_PINS         = 16;
    localparam int unsigned PRESCALE_DEFAULT = 12;
    localparam int unsigned PRESC_W          = 16;
    localparam int unsigned CFG_BYTES        = 5;

    localparam logic [PWM_BITS-1:0] DUTY_FULL = 8'hFF;

    typedef struct packed {
        logic [NUM_PINS-1:0] en_out;
        logic [NUM_PINS-1:0] en_pwm;
        logic [PWM_BITS-1:0] duty;
    } pwm_cfg_t;

    // DUTY_FULL is special-cased so that full scale really means always high.
    function automatic logic duty_level(input logic [PWM_BITS-1:0] cnt,
                                        input logic [PWM_BITS-1:0] duty);
        return (duty == DUTY_FULL) || (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_cfg_sync.sv
// Synchronizer for one quasi-static configuration field from the sclk domain.
// The live copy only follows the chain when its last two stages agree.
module pwm_cfg_sync
    import pwm_pkg::*;
#(
    parameter int unsigned Width      = PWM_BITS,
    parameter int unsigned SyncStages = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] cfg_i,
    output logic [Width-1:0] live_o
);

    logic [Width-1:0] sync_q [SyncStages];
    logic [Width-1:0] sync_d [SyncStages];
    logic [Width-1:0] live_q;
    logic [Width-1:0] live_d;

    always_comb begin
        sync_d[0] = cfg_i;
        for (int unsigned i = 1; i < SyncStages; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        live_d = live_q;
        // Disagreement means a change is still in flight; keep the old value whole.
        if (sync_q[SyncStages-1] == sync_q[SyncStages-2]) begin
            live_d = sync_q[SyncStages-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '{default: '0};
            live_q <= '0;
        end else begin
            sync_q <= sync_d;
            live_q <= live_d;
        end
    end

    assign live_o = live_q;

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin output stage: config capture, prescaler, 8-bit PWM counter, duty compare, pin mux.
// Define PWM_SHADOW_EN to make duty updates take effect only at period boundaries.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE    = PRESCALE_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          en_reg_out_7_0,
    input  logic [7:0]          en_reg_out_15_8,
    input  logic [7:0]          en_reg_pwm_7_0,
    input  logic [7:0]          en_reg_pwm_15_8,
    input  logic [7:0]          pwm_duty_cycle,
    output logic [NUM_PINS-1:0] out,
    output logic                period_start
);

    localparam logic [PRESC_W-1:0]  PrescLast = PRESC_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CntLast   = '1;

    pwm_cfg_t                  cfg_raw;
    pwm_cfg_t                  cfg_live;
    logic [CFG_BYTES*8-1:0]    raw_bits;
    logic [CFG_BYTES*8-1:0]    live_bits;

    assign cfg_raw = '{
        en_out: {en_reg_out_15_8, en_reg_out_7_0},
        en_pwm: {en_reg_pwm_15_8, en_reg_pwm_7_0},
        duty:   pwm_duty_cycle
    };
    assign raw_bits = cfg_raw;
    assign cfg_live = pwm_cfg_t'(live_bits);

    // Per-byte capture: each byte is written as a unit on the SPI side.
    for (genvar b = 0; b < CFG_BYTES; b++) begin : g_sync
        pwm_cfg_sync #(
            .Width      (8),
            .SyncStages (SYNC_STAGES)
        ) u_cfg_sync (
            .clk_i  (clk),
            .rst_ni (rst),
            .cfg_i  (raw_bits[b*8 +: 8]),
            .live_o (live_bits[b*8 +: 8])
        );
    end

    logic [PRESC_W-1:0]  presc_cnt_q, presc_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                period_start_q, period_start_d;
    logic [NUM_PINS-1:0] out_q, out_d;
    logic                tick;
    logic [PWM_BITS-1:0] duty_eff;
    logic                pwm_level;

    assign tick = (presc_cnt_q == PrescLast);

    always_comb begin
        presc_cnt_d    = tick ? '0 : presc_cnt_q + PRESC_W'(1);
        pwm_cnt_d      = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
        period_start_d = tick && (pwm_cnt_q == CntLast);
    end

`ifdef PWM_SHADOW_EN
    logic [PWM_BITS-1:0] duty_shadow_q, duty_shadow_d;

    // Loads on the period_start edge, so a whole period always uses one duty.
    always_comb begin
        duty_shadow_d = period_start_d ? cfg_live.duty : duty_shadow_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_shadow_q <= '0;
        end else begin
            duty_shadow_q <= duty_shadow_d;
        end
    end

    assign duty_eff = duty_shadow_q;
`else
    assign duty_eff = cfg_live.duty;
`endif

    assign pwm_level = duty_level(pwm_cnt_q, duty_eff);

    always_comb begin
        out_d = cfg_live.en_out & (~cfg_live.en_pwm | {NUM_PINS{pwm_level}});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_cnt_q    <= '0;
            pwm_cnt_q      <= '0;
            period_start_q <= 1'b0;
            out_q          <= '0;
        end else begin
            presc_cnt_q    <= presc_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            period_start_q <= period_start_d;
            out_q          <= out_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Randomized and directed checks of pwm_peripheral against a cycle-count reference model.
// Honours PWM_SHADOW_EN in the model the same way the design does.
module tb_pwm_peripheral;

    localparam int P      = 12;
    localparam int PERIOD = P * 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cur_en_out = '0;
    logic [15:0] cur_en_pwm = '0;
    logic [7:0]  cur_duty   = '0;
    logic [15:0] out;
    logic        period_start;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // hist[e] holds the input bundle present just before clk edge e after reset release.
    logic [39:0] hist[$];
    int          m;

    pwm_peripheral #(
        .PRESCALE    (P),
        .SYNC_STAGES (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (cur_en_out[7:0]),
        .en_reg_out_15_8 (cur_en_out[15:8]),
        .en_reg_pwm_7_0  (cur_en_pwm[7:0]),
        .en_reg_pwm_15_8 (cur_en_pwm[15:8]),
        .pwm_duty_cycle  (cur_duty),
        .out             (out),
        .period_start    (period_start)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] cfg_at(input int idx);
        if (idx < 1 || idx >= hist.size()) return '0;
        return hist[idx];
    endfunction

    // Out after edge e reflects inputs seen 3 edges earlier and the PWM count before edge e.
    function automatic logic [15:0] exp_out(input int e);
        logic [39:0] c;
        logic [39:0] s;
        logic [7:0]  duty;
        logic        level;
        logic [15:0] r;
        int          cnt;
        int          p;
        c   = cfg_at(e - 3);
        cnt = ((e - 1) / P) % 256;
`ifdef PWM_SHADOW_EN
        p    = (e - 1) / PERIOD;
        s    = (p == 0) ? 40'h0 : cfg_at(p * PERIOD - 3);
        duty = s[7:0];
`else
        p    = 0;
        s    = c;
        duty = s[7:0];
`endif
        level = (duty == 8'hFF) || (cnt < int'(duty));
        for (int i = 0; i < 16; i++) begin
            r[i] = c[24+i] ? (c[8+i] ? level : 1'b1) : 1'b0;
        end
        return r;
    endfunction

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s edge=%0d observed=%h expected=%h", tag, m, obs, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, m, obs, expv);
        end
    endtask

    task automatic reset_model();
        hist.delete();
        hist.push_back('0);
        m = 0;
    endtask

    task automatic step();
        @(posedge clk);
        m++;
        hist.push_back({cur_en_out, cur_en_pwm, cur_duty});
        #1;
        chk16("out", out, exp_out(m));
        chk16("period_start", {15'h0, period_start}, {15'h0, (m % PERIOD) == 0});
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_to_boundary();
        do step(); while ((m % PERIOD) != 0);
    endtask

    task automatic run_to_cnt(input int target);
        for (int k = 0; k < PERIOD && ((m / P) % 256) != target; k++) step();
    endtask

    initial begin
        int pulses;
        int hi0;
        int hi15;
        int hi_a;
        int hi_b;
        bit changed;

        reset_model();
        #1 rst = 1'b0;
        #1;
        chk16("reset_out", out, 16'h0);
        chk16("reset_period_start", {15'h0, period_start}, 16'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Idle for two periods: pulses exactly at 3072 and 6144.
        pulses = 0;
        for (int k = 0; k < 2 * PERIOD + 2; k++) begin
            step();
            if (period_start) pulses++;
        end
        chk_int("idle_pulses", pulses, 2);

        // Static high on the low nibble.
        cur_en_out = 16'h000F;
        run(4);
        chk16("static_high", out, 16'h000F);
        run(20);

        // 50 % on all pins.
        cur_en_out = 16'hFFFF;
        cur_en_pwm = 16'hFFFF;
        cur_duty   = 8'd128;
        run_to_boundary();
        run_to_boundary();
        hi0  = 0;
        hi15 = 0;
        repeat (PERIOD) begin
            step();
            hi0  += int'(out[0]);
            hi15 += int'(out[15]);
        end
        chk_int("duty50_pin0_high", hi0, PERIOD / 2);
        chk_int("duty50_pin15_high", hi15, PERIOD / 2);

        // Extremes.
        cur_duty = 8'd0;
        run(2 * PERIOD);
        cur_duty = 8'hFF;
        run(2 * PERIOD);

        // Mid-period change 64 -> 192 at pwm_cnt 100.
        cur_duty = 8'd64;
        run_to_boundary();
        run_to_boundary();
        hi_a    = 0;
        changed = 1'b0;
        repeat (PERIOD) begin
            step();
            hi_a += int'(out[3]);
            if (!changed && ((m / P) % 256) == 100) begin
                cur_duty = 8'd192;
                changed  = 1'b1;
            end
        end
        hi_b = 0;
        repeat (PERIOD) begin
            step();
            hi_b += int'(out[3]);
        end
`ifdef PWM_SHADOW_EN
        chk_int("shadow_old_period_high", hi_a, 64 * P);
`endif
        chk_int("duty192_period_high", hi_b, 192 * P);

        // Random configurations, each held long enough to pass the stable-sample filter.
        for (int seg = 0; seg < 12; seg++) begin
            cur_en_out = 16'($urandom);
            cur_en_pwm = 16'($urandom);
            cur_duty   = 8'($urandom);
            if (seg == 3) cur_duty = 8'hFF;
            if (seg == 4) cur_duty = 8'h00;
            run(int'($urandom_range(4, 800)));
        end

        // Reset in the middle of a period while pins are high.
        cur_en_out = 16'hFFFF;
        cur_en_pwm = 16'hFFFF;
        cur_duty   = 8'd128;
        run_to_boundary();
        run_to_boundary();
        run_to_cnt(50);
        chk16("pre_reset_high", out, 16'hFFFF);
        #2 rst = 1'b0;
        #1;
        chk16("async_reset_out", out, 16'h0);
        chk16("async_reset_period_start", {15'h0, period_start}, 16'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        reset_model();
        pulses = 0;
        for (int k = 0; k < PERIOD + 4; k++) begin
            step();
            if (period_start) pulses++;
            if (k == PERIOD - 2) chk_int("no_early_pulse", pulses, 0);
        end
        chk_int("post_reset_pulses", pulses, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
